// File: rtl/fetch.sv
// ============================================================================
//  Module   : fetch
//  Purpose  : 2x2 neighbourhood window generator over a raster pixel stream,
//             backed by a single line buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch #(
   parameter int img_width  = 640,
   parameter int img_height = 480
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tdata,
   input  logic       tvalid,
   output logic [7:0] lu,
   output logic [7:0] ru,
   output logic [7:0] ld,
   output logic [7:0] rd,
   output logic       wvalid
);

   localparam int XW = $clog2(img_width);
   localparam int YW = $clog2(img_height);
   localparam logic [XW-1:0] X_LAST = XW'(img_width - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(img_height - 1);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [7:0]    lu_q, lu_d, ru_q, ru_d, ld_q, ld_d, rd_q, rd_d;
   logic          wvalid_q, wvalid_d;
   logic [7:0]    mem_q [img_width];
   logic [7:0]    up_pix;
   logic          x_first, y_first;

   // Asynchronous read gives P(y-1,x) before this beat overwrites the entry.
   assign up_pix  = mem_q[x_q];
   assign x_first = (x_q == '0);
   assign y_first = (y_q == '0);

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      lu_d     = lu_q;
      ru_d     = ru_q;
      ld_d     = ld_q;
      rd_d     = rd_q;
      wvalid_d = wvalid_q;
      if (tvalid) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
         rd_d     = tdata;
         ld_d     = x_first ? 8'h00 : rd_q;
         ru_d     = y_first ? 8'h00 : up_pix;
         lu_d     = (x_first || y_first) ? 8'h00 : ru_q;
         wvalid_d = !x_first && !y_first;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q      <= '0;
         y_q      <= '0;
         lu_q     <= 8'h00;
         ru_q     <= 8'h00;
         ld_q     <= 8'h00;
         rd_q     <= 8'h00;
         wvalid_q <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         lu_q     <= lu_d;
         ru_q     <= ru_d;
         ld_q     <= ld_d;
         rd_q     <= rd_d;
         wvalid_q <= wvalid_d;
      end
   end

   // Contents are never cleared; row-0 masking hides stale data.
   always_ff @(posedge clk) begin
      if (!rst && tvalid) begin
         mem_q[x_q] <= tdata;
      end
   end

   assign lu     = lu_q;
   assign ru     = ru_q;
   assign ld     = ld_q;
   assign rd     = rd_q;
   assign wvalid = wvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch.sv
// ============================================================================
//  Module   : tb_fetch
//  Purpose  : Directed self-checking bench for fetch (16x10 image).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch;

   localparam int W = 16;
   localparam int H = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tdata;
   logic       tvalid;
   logic [7:0] lu, ru, ld, rd;
   logic       wvalid;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch #(
      .img_width (W),
      .img_height(H)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .tdata (tdata),
      .tvalid(tvalid),
      .lu    (lu),
      .ru    (ru),
      .ld    (ld),
      .rd    (rd),
      .wvalid(wvalid)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic chk_win(input string tag, input logic [7:0] e_lu, input logic [7:0] e_ru,
                          input logic [7:0] e_ld, input logic [7:0] e_rd, input logic e_wv);
      chk({tag, ".lu"}, lu, e_lu);
      chk({tag, ".ru"}, ru, e_ru);
      chk({tag, ".ld"}, ld, e_ld);
      chk({tag, ".rd"}, rd, e_rd);
      chk({tag, ".wvalid"}, {7'd0, wvalid}, {7'd0, e_wv});
   endtask

   function automatic logic [7:0] px(input int yy, input int xx);
      return {yy[3:0], xx[3:0]};
   endfunction

   // Feed pixel {y,x} and check the window against the neighbourhood definition.
   task automatic beat(input int y, input int x);
      logic [7:0] e_lu, e_ru, e_ld;
      @(negedge clk);
      rst    = 1'b0;
      tvalid = 1'b1;
      tdata  = px(y, x);
      @(posedge clk);
      #1;
      e_ld = (x > 0) ? px(y, x - 1) : 8'h00;
      e_ru = (y > 0) ? px(y - 1, x) : 8'h00;
      e_lu = (x > 0 && y > 0) ? px(y - 1, x - 1) : 8'h00;
      chk_win($sformatf("px_%0d_%0d", y, x), e_lu, e_ru, e_ld, px(y, x), (x > 0 && y > 0));
   endtask

   initial begin
      rst    = 1'b1;
      tvalid = 1'b1;
      tdata  = 8'hA5;

      // Reset held with tvalid high.
      repeat (5) @(posedge clk);
      #1;
      chk_win("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

      // Frame 1, with an idle gap after 0x46.
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            beat(y, x);
            if (y == 0 && x == 0) chk_win("first", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
            if (y == 0 && x == 3) chk_win("row0",  8'h00, 8'h00, 8'h02, 8'h03, 1'b0);
            if (y == 3 && x == 5) chk_win("int35", 8'h24, 8'h25, 8'h34, 8'h35, 1'b1);
            if (y == 9 && x == 15) chk_win("int9F", 8'h8E, 8'h8F, 8'h9E, 8'h9F, 1'b1);
            if (y == 2 && x == 0) chk_win("col0",  8'h00, 8'h10, 8'h00, 8'h20, 1'b0);
            if (y == 4 && x == 7) chk_win("resume", 8'h36, 8'h37, 8'h46, 8'h47, 1'b1);
            if (y == 4 && x == 6) begin
               for (int i = 0; i < 7; i++) begin
                  @(negedge clk);
                  tvalid = 1'b0;
                  tdata  = 8'($urandom);
                  @(posedge clk);
                  #1;
                  chk_win($sformatf("idle%0d", i), 8'h35, 8'h36, 8'h45, 8'h46, 1'b1);
               end
            end
         end
      end

      // Frame 2 up to 0x52; row 0 must be masked despite a full line buffer.
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (y < 5 || (y == 5 && x < 3)) begin
               beat(y, x);
               if (y == 0 && x == 0) chk_win("wrap", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
            end
         end
      end

      // Reset pulse while 0x53 is presented; reset wins over tvalid.
      @(negedge clk);
      rst    = 1'b1;
      tvalid = 1'b1;
      tdata  = 8'h53;
      @(posedge clk);
      #1;
      chk_win("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

      // Restart from (0,0).
      for (int y = 0; y < 2; y++) begin
         for (int x = 0; x < W; x++) begin
            beat(y, x);
            if (y == 0 && x == 3) chk_win("rst_row0", 8'h00, 8'h00, 8'h02, 8'h03, 1'b0);
            if (y == 1 && x == 0) chk_win("rst_col0", 8'h00, 8'h00, 8'h00, 8'h10, 1'b0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch.md
# fetch

The `fetch` block produces a 2x2 neighbourhood window over a raster-scanned 8-bit pixel stream. It buffers one image line and, for every accepted pixel, outputs that pixel together with its left, upper and upper-left neighbours. It feeds the bilinear-interpolation stage of the rectification pipeline and sits directly behind the AXI-Stream-style pixel source.

## Interface
- `img_width`, default 640: pixels per line; must be ≥ 2.
- `img_height`, default 480: lines per frame; must be ≥ 2.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tdata`  in  8  incoming pixel, raster order (left to right, top to bottom).
- `tvalid`  in  1  `tdata` is accepted on every rising edge where `tvalid`=1.
- `lu`  out  8  upper-left neighbour, P(y-1, x-1).
- `ru`  out  8  upper neighbour, P(y-1, x).
- `ld`  out  8  left neighbour, P(y, x-1).
- `rd`  out  8  current pixel, P(y, x).
- `wvalid`  out  1  window lies fully inside the image (y≥1 and x≥1).

## Operation
- **No backpressure.** There is no `tready`; every `tvalid` beat is consumed.
- **Position counters.** Internal column counter x (0..`img_width`-1) and row counter y (0..`img_height`-1) track the position of the pixel being accepted.
  - Each accepted beat increments x.
  - At x=`img_width`-1, x wraps to 0 and y increments.
  - At y=`img_height`-1 with x=`img_width`-1, y wraps to 0, which starts a new frame.
- **Line buffer.** `img_width` entries of 8 bits, indexed by x.
  - On an accepted beat, entry x is read (yielding P(y-1,x)) and then overwritten with `tdata`, in the same cycle.
  - Read-before-write ordering is mandatory.
  - Storage may be a RAM with asynchronous read or a shift register.
- **Output update on an accepted beat:**
  - `rd` ← `tdata`
  - `ld` ← previous `rd`, or 0 if x=0
  - `ru` ← line-buffer read, or 0 if y=0
  - `lu` ← previous `ru`, or 0 if x=0 or y=0
  - `wvalid` ← (x≥1 && y≥1)
- **Idle cycles.** With `tvalid`=0, all outputs, counters and the line buffer hold.
- **Boundary masking:**
  - Column 0 never takes left neighbours from the end of the previous line; they are forced to 0.
  - Row 0 of every frame forces the upper neighbours to 0, even though the line buffer still holds the previous frame's last line.
- **Reset:**
  - `rst`=1 forces `lu`, `ru`, `ld`, `rd` = 0 and `wvalid` = 0.
  - It also forces x=0 and y=0.
  - Line-buffer contents need not be cleared, because row-0 masking hides them.
  - Reset mid-frame restarts at pixel (0,0) on the next accepted beat.
  - `rst` has priority over `tvalid`.

## Timing
- **Latency.** Pixel accepted at edge N appears on `rd` right after edge N (registered outputs, 1-cycle latency). Its full window is valid in that same cycle.
- **Output changes.** Outputs change only on edges with `tvalid`=1 or `rst`=1.
- **Throughput.** One pixel per clock sustained, with no bubbles required between lines or frames.
- **Counter/output consistency.** Counter wrap and output update use the pre-increment x/y of the beat being accepted.

## Test plan
All scenarios use `img_width`=16, `img_height`=10, and `tdata`={y[3:0], x[3:0]}, streamed continuously after reset.
1. **Reset.** Hold `rst` 5 cycles with `tvalid`=1 → all outputs 0, `wvalid`=0. First beat after release accepts 0x00: `rd`=0x00, `ld`/`ru`/`lu`=0, `wvalid`=0.
2. **Row 0, interior.** After accepting 0x03 → `rd`=0x03, `ld`=0x02, `ru`=0x00, `lu`=0x00, `wvalid`=0.
3. **Interior.** After accepting 0x35 → `rd`=0x35, `ld`=0x34, `ru`=0x25, `lu`=0x24, `wvalid`=1. After 0x9F → `rd`=0x9F, `ld`=0x9E, `ru`=0x8F, `lu`=0x8E.
4. **Column 0.** After accepting 0x20 → `rd`=0x20, `ld`=0, `ru`=0x10, `lu`=0, `wvalid`=0 (not 0x1F from the previous line).
5. **Idle hold.** Drop `tvalid` for 7 cycles after accepting 0x46 → outputs stay 0x46/0x45/0x36/0x35. Resuming with 0x47 → `rd`=0x47, `ld`=0x46, `ru`=0x37, `lu`=0x36.
6. **Frame wrap and mid-frame reset.**
   - After 160 beats, the next beat 0x00 → `ru`=`lu`=0 and `wvalid`=0; the row-0 pattern repeats.
   - Pulse `rst` at pixel 0x53, then resume feeding from 0x00 → behaves exactly as scenario 1.
